// File: rtl/rstp_dbg_pkg.sv
// rtl/rstp_dbg_pkg.sv - shared T2H CSR offsets, fault value and descriptor type
package rstp_dbg_pkg;

  localparam logic [3:0]  T2H_GRP_SEL      = 4'h2;

  localparam logic [11:0] T2H_OFF_LEN      = 12'h208;
  localparam logic [11:0] T2H_OFF_START    = 12'h20C;
  localparam logic [11:0] T2H_OFF_CONN     = 12'h210;
  localparam logic [11:0] T2H_OFF_CHAN     = 12'h214;
  localparam logic [11:0] T2H_OFF_DONE     = 12'h218;

  localparam logic [31:0] DBG_IP_FAULT_VAL = 32'hDEAD_C0DE;

  typedef struct packed {
    logic        last;
    logic [30:0] len;
    logic [31:0] start_loc;
    logic [31:0] conn_id;
    logic [31:0] chan_id;
  } t2h_desc_t;

endpackage

// File: rtl/rstp_desc_fifo.sv
// rtl/rstp_desc_fifo.sv - show-ahead synchronous descriptor FIFO with occupancy
module rstp_desc_fifo
  import rstp_dbg_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  t2h_desc_t        wr_data,
  input  logic             pop,
  output t2h_desc_t        rd_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             full,
  output logic             empty
);

  t2h_desc_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Occupancy tracks both ends in one step so a simultaneous push and pop nets to zero
  always_comb begin
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Pointer and occupancy state; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage is left unreset; the head is only consumed when occupancy says it is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/rstp_t2h_desc_csr.sv
// rtl/rstp_t2h_desc_csr.sv - T2H descriptor queue with host CSR read, pop and release
module rstp_t2h_desc_csr
  import rstp_dbg_pkg::*;
#(
  parameter int DESC_DEPTH = 32,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [30:0]                 desc_len,
  input  logic                        desc_last,
  input  logic [31:0]                 desc_start_loc,
  input  logic [31:0]                 desc_conn_id,
  input  logic [31:0]                 desc_chan_id,
  input  logic                        csr_write,
  input  logic                        csr_read,
  input  logic [ADDR_W-1:0]           csr_address,
  input  logic [31:0]                 csr_writedata,
  output logic [DATA_W-1:0]           csr_readdata,
  output logic                        csr_readdatavalid,
  input  logic                        intr_mask_t2h,
  output logic                        t2h_irq,
  output logic [$clog2(DESC_DEPTH):0] desc_count,
  output logic                        rel_valid,
  output logic [31:0]                 rel_start_loc,
  output logic [30:0]                 rel_len,
  output logic                        err_pop_empty
);

  localparam int CNT_W = $clog2(DESC_DEPTH) + 1;

  t2h_desc_t          push_desc;
  t2h_desc_t          head;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   fifo_count_nxt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_do;
  logic               grp_hit;
  logic               rd_acc;
  logic               pop_req;
  logic               pop_do;
  logic [DATA_W-1:0]  rd_mux;

  logic [DATA_W-1:0]  readdata_q;
  logic               readdatavalid_q;
  logic               rel_valid_q;
  logic [31:0]        rel_start_loc_q;
  logic [30:0]        rel_len_q;
  logic               err_pop_empty_q;
  logic               irq_q;

  // Pop is triggered by the write strobe alone; the data word carries no meaning
  logic               unused_wdata;
  assign unused_wdata = ^csr_writedata;

  assign push_desc = '{last: desc_last, len: desc_len, start_loc: desc_start_loc,
                       conn_id: desc_conn_id, chan_id: desc_chan_id};

  assign desc_ready = !fifo_full;
  assign push_do    = desc_valid && desc_ready;
  assign grp_hit    = (csr_address[11:8] == T2H_GRP_SEL);
  assign rd_acc     = csr_read && grp_hit;
  assign pop_req    = csr_write && grp_hit && (csr_address[11:0] == T2H_OFF_DONE);
  assign pop_do     = pop_req && !fifo_empty;

  rstp_desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_do),
    .wr_data   (push_desc),
    .pop       (pop_do),
    .rd_data   (head),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Read mux over the current (pre-pop) head; an empty queue reads as zero
  always_comb begin
    rd_mux = DBG_IP_FAULT_VAL;
    case (csr_address[11:0])
      T2H_OFF_LEN:   rd_mux = fifo_empty ? '0 : {head.last, head.len};
      T2H_OFF_START: rd_mux = fifo_empty ? '0 : head.start_loc;
      T2H_OFF_CONN:  rd_mux = fifo_empty ? '0 : head.conn_id;
      T2H_OFF_CHAN:  rd_mux = fifo_empty ? '0 : head.chan_id;
      T2H_OFF_DONE:  rd_mux = '0;
      default:       rd_mux = DBG_IP_FAULT_VAL;
    endcase
  end

  // Registered read response, release pulse, empty-pop error and interrupt level
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      rel_valid_q     <= 1'b0;
      rel_start_loc_q <= '0;
      rel_len_q       <= '0;
      err_pop_empty_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      readdatavalid_q <= rd_acc;
      if (rd_acc) readdata_q <= rd_mux;
      rel_valid_q <= pop_do;
      if (pop_do) begin
        rel_start_loc_q <= head.start_loc;
        rel_len_q       <= head.len;
      end
      err_pop_empty_q <= pop_req && fifo_empty;
      irq_q           <= (fifo_count_nxt != '0) && !intr_mask_t2h;
    end
  end

  assign csr_readdata      = readdata_q;
  assign csr_readdatavalid = readdatavalid_q;
  assign rel_valid         = rel_valid_q;
  assign rel_start_loc     = rel_start_loc_q;
  assign rel_len           = rel_len_q;
  assign err_pop_empty     = err_pop_empty_q;
  assign t2h_irq           = irq_q;
  assign desc_count        = fifo_count;

endmodule

// File: tb/tb_rstp_t2h_desc_csr.sv
// tb/tb_rstp_t2h_desc_csr.sv - directed self-checking bench for the T2H descriptor CSR block
module tb_rstp_t2h_desc_csr;
  import rstp_dbg_pkg::*;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  t2h_desc_t   din = '0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [11:0] csr_address = '0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic        csr_readdatavalid;
  logic        intr_mask_t2h = 1'b0;
  logic        t2h_irq;
  logic [5:0]  desc_count;
  logic        rel_valid;
  logic [31:0] rel_start_loc;
  logic [30:0] rel_len;
  logic        err_pop_empty;

  rstp_t2h_desc_csr #(.DESC_DEPTH(DEPTH), .ADDR_W(12), .DATA_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_len          (din.len),
    .desc_last         (din.last),
    .desc_start_loc    (din.start_loc),
    .desc_conn_id      (din.conn_id),
    .desc_chan_id      (din.chan_id),
    .csr_write         (csr_write),
    .csr_read          (csr_read),
    .csr_address       (csr_address),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .intr_mask_t2h     (intr_mask_t2h),
    .t2h_irq           (t2h_irq),
    .desc_count        (desc_count),
    .rel_valid         (rel_valid),
    .rel_start_loc     (rel_start_loc),
    .rel_len           (rel_len),
    .err_pop_empty     (err_pop_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rv [14];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic t2h_desc_t mk(input logic [30:0] len, input logic last,
                                   input logic [31:0] loc, input logic [31:0] conn,
                                   input logic [31:0] chan);
    t2h_desc_t d;
    d.last = last; d.len = len; d.start_loc = loc; d.conn_id = conn; d.chan_id = chan;
    return d;
  endfunction

  // All tasks start and end just after a falling edge
  task automatic do_read(input logic [11:0] a, input logic [31:0] exp, input string nm);
    csr_read = 1'b1; csr_address = a;
    @(negedge clk);
    csr_read = 1'b0;
    chk({nm, "_valid"}, 32'(csr_readdatavalid), 32'd1);
    chk(nm, csr_readdata, exp);
  endtask

  task automatic run_reads(input int lo, input int hi, input string nm);
    for (int i = lo; i <= hi; i++) begin
      do_read(rv[i].addr, rv[i].exp, $sformatf("%s_%03h", nm, rv[i].addr));
    end
  endtask

  task automatic push(input t2h_desc_t d);
    desc_valid = 1'b1; din = d;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic pop_chk(input t2h_desc_t e, input string nm);
    csr_write = 1'b1; csr_address = T2H_OFF_DONE;
    @(negedge clk);
    csr_write = 1'b0;
    chk({nm, "_rel_valid"}, 32'(rel_valid), 32'd1);
    chk({nm, "_rel_loc"}, rel_start_loc, e.start_loc);
    chk({nm, "_rel_len"}, 32'(rel_len), 32'(e.len));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    t2h_desc_t a, b, c, d, e, f;
    a = mk(31'h40, 1'b1, 32'h100, 32'd5, 32'd2);
    b = mk(31'h80, 1'b0, 32'h200, 32'd6, 32'd3);
    c = mk(31'h11, 1'b1, 32'h300, 32'd7, 32'd8);
    d = mk(31'h22, 1'b0, 32'h400, 32'd9, 32'd10);
    e = mk(31'h33, 1'b1, 32'h500, 32'd11, 32'd12);

    rv[0]  = '{12'h208, 32'h0};
    rv[1]  = '{12'h20C, 32'h0};
    rv[2]  = '{12'h210, 32'h0};
    rv[3]  = '{12'h214, 32'h0};
    rv[4]  = '{12'h2F0, 32'hDEAD_C0DE};
    rv[5]  = '{12'h218, 32'h0};
    rv[6]  = '{12'h208, 32'h8000_0040};
    rv[7]  = '{12'h20C, 32'h100};
    rv[8]  = '{12'h210, 32'd5};
    rv[9]  = '{12'h214, 32'd2};
    rv[10] = '{12'h208, 32'h0000_0080};
    rv[11] = '{12'h20C, 32'h200};
    rv[12] = '{12'h210, 32'd6};
    rv[13] = '{12'h214, 32'd3};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 32'(desc_count), 32'd0);
    chk("rst_ready", 32'(desc_ready), 32'd1);
    chk("rst_irq", 32'(t2h_irq), 32'd0);
    chk("rst_rdv", 32'(csr_readdatavalid), 32'd0);
    chk("rst_rel", 32'(rel_valid), 32'd0);
    chk("rst_err", 32'(err_pop_empty), 32'd0);

    run_reads(0, 5, "empty");
    @(negedge clk);
    chk("rdv_one_cycle", 32'(csr_readdatavalid), 32'd0);
    csr_read = 1'b1; csr_address = 12'h308;
    @(negedge clk);
    csr_read = 1'b0;
    chk("out_of_group_rdv", 32'(csr_readdatavalid), 32'd0);

    push(a);
    push(b);
    chk("two_count", 32'(desc_count), 32'd2);
    chk("two_irq", 32'(t2h_irq), 32'd1);
    run_reads(6, 9, "headA");

    csr_write = 1'b1; csr_address = 12'h118;
    @(negedge clk);
    csr_write = 1'b0;
    chk("foreign_write_rel", 32'(rel_valid), 32'd0);
    chk("foreign_write_count", 32'(desc_count), 32'd2);

    pop_chk(a, "popA");
    @(negedge clk);
    chk("popA_rel_drop", 32'(rel_valid), 32'd0);
    chk("popA_count", 32'(desc_count), 32'd1);
    run_reads(10, 13, "headB");
    pop_chk(b, "popB");
    chk("popB_irq", 32'(t2h_irq), 32'd0);
    chk("popB_count", 32'(desc_count), 32'd0);

    for (int i = 0; i < DEPTH; i++) push(mk(31'(i + 1), i[0], 32'(i * 16), 32'(i), ~32'(i)));
    chk("full_count", 32'(desc_count), 32'd32);
    chk("full_ready", 32'(desc_ready), 32'd0);
    push(mk(31'h7FFF, 1'b1, 32'hFFFF, 32'd99, 32'd99));
    chk("full_holdoff_count", 32'(desc_count), 32'd32);
    pop_chk(mk(31'd1, 1'b0, 32'd0, 32'd0, ~32'd0), "fill_pop0");
    chk("after_full_pop_ready", 32'(desc_ready), 32'd1);
    chk("after_full_pop_count", 32'(desc_count), 32'd31);
    for (int i = 1; i < DEPTH; i++)
      pop_chk(mk(31'(i + 1), i[0], 32'(i * 16), 32'(i), ~32'(i)), $sformatf("fill_pop%0d", i));
    chk("drain_count", 32'(desc_count), 32'd0);

    push(c);
    desc_valid = 1'b1; din = d;
    csr_write = 1'b1; csr_read = 1'b1; csr_address = T2H_OFF_DONE;
    @(negedge clk);
    desc_valid = 1'b0; csr_write = 1'b0; csr_read = 1'b0;
    chk("pushpop_count", 32'(desc_count), 32'd1);
    chk("pushpop_rel_loc", rel_start_loc, c.start_loc);
    chk("pushpop_rdv", 32'(csr_readdatavalid), 32'd1);
    chk("pushpop_rdata", csr_readdata, 32'd0);
    do_read(T2H_OFF_LEN, {d.last, d.len}, "pushpop_newhead");
    pop_chk(d, "popD");

    csr_write = 1'b1; csr_address = T2H_OFF_DONE;
    @(negedge clk);
    csr_write = 1'b0;
    chk("empty_pop_err", 32'(err_pop_empty), 32'd1);
    chk("empty_pop_rel", 32'(rel_valid), 32'd0);
    chk("empty_pop_count", 32'(desc_count), 32'd0);
    @(negedge clk);
    chk("empty_pop_err_drop", 32'(err_pop_empty), 32'd0);

    intr_mask_t2h = 1'b1;
    push(e);
    chk("mask_irq0", 32'(t2h_irq), 32'd0);
    @(negedge clk);
    chk("mask_irq1", 32'(t2h_irq), 32'd0);
    intr_mask_t2h = 1'b0;
    @(negedge clk);
    chk("unmask_irq", 32'(t2h_irq), 32'd1);
    pop_chk(e, "popE");
    chk("popE_irq", 32'(t2h_irq), 32'd0);

    for (int i = 0; i < 5; i++) push(mk(31'(i), 1'b0, 32'(i), 32'(i), 32'(i)));
    chk("pre_rst_count", 32'(desc_count), 32'd5);
    chk("pre_rst_irq", 32'(t2h_irq), 32'd1);
    csr_read = 1'b1; csr_address = T2H_OFF_LEN; rst = 1'b1;
    @(negedge clk);
    csr_read = 1'b0; rst = 1'b0;
    chk("mid_rst_count", 32'(desc_count), 32'd0);
    chk("mid_rst_rdv", 32'(csr_readdatavalid), 32'd0);
    chk("mid_rst_irq", 32'(t2h_irq), 32'd0);
    chk("mid_rst_ready", 32'(desc_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
